biquad_power_monitor: RTL and testbench

//  Downstream of the biquad8 wrapper: consumes the NSAMP-parallel filtered

---
 rtl/biquad_power_monitor.sv | 130 +++++++++++++
 tb/tb_biquad_power_monitor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/biquad_power_monitor.sv
// Windowed power / peak monitor for the parallel biquad output stream.
// Three-stage pipeline: square/abs per lane, lane reduce, window accumulate.
module biquad_power_monitor #(
    parameter int NSAMP       = 4,
    parameter int NBITS       = 16,
    parameter int LOG2_WINDOW = 10,
    localparam int ACCW       = 2*NBITS-1 + $clog2(NSAMP) + LOG2_WINDOW
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NSAMP*NBITS-1:0] dat_i,
    input  logic                   enable_i,
    input  logic                   clear_i,
    output logic [ACCW-1:0]        power_o,
    output logic [NBITS-1:0]       peak_o,
    output logic                   valid_o
);
    localparam int SQW  = 2*NBITS-1;
    localparam int SUMW = SQW + $clog2(NSAMP);

    logic signed [NBITS-1:0]   ds_c   [NSAMP];
    logic signed [2*NBITS-1:0] prod_c [NSAMP];
    logic [SQW-1:0]            sq_c   [NSAMP];
    logic [NBITS-1:0]          ab_c   [NSAMP];

    logic [SQW-1:0]         sq   [NSAMP];
    logic [NBITS-1:0]       ab   [NSAMP];
    logic                   tag_v1, tag_last1;
    logic [LOG2_WINDOW-1:0] wcnt;

    logic [SUMW-1:0]        sum_c, sum;
    logic [NBITS-1:0]       pk_c, pk;
    logic                   tag_v2, tag_last2;

    logic [ACCW-1:0]        acc, acc_next;
    logic [NBITS-1:0]       pkacc, pkacc_next;

    always_comb begin
        for (int i = 0; i < NSAMP; i++) begin
            ds_c[i]   = dat_i[i*NBITS +: NBITS];
            prod_c[i] = (2*NBITS)'(ds_c[i]) * (2*NBITS)'(ds_c[i]);
            // The square of any NBITS signed value fits in 2*NBITS-1 bits.
            sq_c[i]   = prod_c[i][SQW-1:0];
            ab_c[i]   = ds_c[i][NBITS-1] ? (NBITS'(0) - NBITS'(ds_c[i])) : NBITS'(ds_c[i]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NSAMP; i++) begin
                sq[i] <= '0;
                ab[i] <= '0;
            end
            tag_v1    <= 1'b0;
            tag_last1 <= 1'b0;
            wcnt      <= '0;
        end else begin
            for (int i = 0; i < NSAMP; i++) begin
                sq[i] <= sq_c[i];
                ab[i] <= ab_c[i];
            end
            if (clear_i) begin
                tag_v1    <= 1'b0;
                tag_last1 <= 1'b0;
                wcnt      <= '0;
            end else begin
                tag_v1    <= enable_i;
                tag_last1 <= enable_i && (wcnt == '1);
                if (enable_i)
                    wcnt <= wcnt + 1'b1;
            end
        end
    end

    always_comb begin
        sum_c = '0;
        pk_c  = '0;
        for (int i = 0; i < NSAMP; i++) begin
            sum_c = sum_c + SUMW'(sq[i]);
            if (ab[i] > pk_c)
                pk_c = ab[i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum       <= '0;
            pk        <= '0;
            tag_v2    <= 1'b0;
            tag_last2 <= 1'b0;
        end else begin
            sum       <= sum_c;
            pk        <= pk_c;
            tag_v2    <= clear_i ? 1'b0 : tag_v1;
            tag_last2 <= clear_i ? 1'b0 : tag_last1;
        end
    end

    always_comb begin
        acc_next   = acc + ACCW'(sum);
        pkacc_next = (pk > pkacc) ? pk : pkacc;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc     <= '0;
            pkacc   <= '0;
            power_o <= '0;
            peak_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (clear_i) begin
                acc   <= '0;
                pkacc <= '0;
            end else if (tag_v2) begin
                if (tag_last2) begin
                    power_o <= acc_next;
                    peak_o  <= pkacc_next;
                    valid_o <= 1'b1;
                    acc     <= '0;
                    pkacc   <= '0;
                end else begin
                    acc   <= acc_next;
                    pkacc <= pkacc_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_biquad_power_monitor.sv
// Bench for biquad_power_monitor: window-level reference model checked every
// cycle, plus literal expectations for each directed scenario.
module tb_biquad_power_monitor;
    localparam int NSAMP = 4;
    localparam int NBITS = 16;
    localparam int L     = 4;
    localparam int WIN   = 16;
    localparam int ACCW  = 2*NBITS-1 + 2 + L;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [NSAMP*NBITS-1:0] dat_i;
    logic                   enable_i;
    logic                   clear_i;
    logic [ACCW-1:0]        power_o;
    logic [NBITS-1:0]       peak_o;
    logic                   valid_o;

    biquad_power_monitor #(.NSAMP(NSAMP), .NBITS(NBITS), .LOG2_WINDOW(L)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .dat_i(dat_i), .enable_i(enable_i),
        .clear_i(clear_i), .power_o(power_o), .peak_o(peak_o), .valid_o(valid_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference: a window closes on the edge taking its 16th enabled sample and
    // is reported two edges later unless a clear or reset intervenes.
    typedef struct { int due; longint p; int pk; } res_t;
    res_t   pend[$];
    int     ecnt = 0;
    int     m_cnt = 0;
    longint m_acc = 0;
    int     m_pk = 0;
    longint m_power = 0;
    int     m_peak = 0;
    bit     m_valid = 0;

    longint s_pow[$];
    int     s_pk[$];
    int     s_edge[$];

    function automatic int absv(input logic [15:0] v);
        int s;
        s = int'($signed(v));
        return (s < 0) ? -s : s;
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_cnt = 0; m_acc = 0; m_pk = 0;
            m_power = 0; m_peak = 0; m_valid = 0;
            pend.delete();
        end else begin
            ecnt++;
            m_valid = 0;
            if (clear_i) begin
                pend.delete();
                m_cnt = 0; m_acc = 0; m_pk = 0;
            end else begin
                if (pend.size() > 0 && pend[0].due == ecnt) begin
                    m_power = pend[0].p;
                    m_peak  = pend[0].pk;
                    m_valid = 1;
                    void'(pend.pop_front());
                end
                if (enable_i) begin
                    for (int i = 0; i < NSAMP; i++) begin
                        longint s;
                        s = longint'($signed(dat_i[i*16 +: 16]));
                        m_acc += s * s;
                        if (absv(dat_i[i*16 +: 16]) > m_pk) m_pk = absv(dat_i[i*16 +: 16]);
                    end
                    m_cnt++;
                    if (m_cnt == WIN) begin
                        pend.push_back('{due: ecnt + 2, p: m_acc, pk: m_pk});
                        m_cnt = 0; m_acc = 0; m_pk = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk_i) begin
        checks++;
        if (valid_o !== m_valid) begin
            errors++;
            $display("FAIL valid_o t=%0t: got %0b expected %0b", $time, valid_o, m_valid);
        end
        checks++;
        if (power_o !== ACCW'(m_power)) begin
            errors++;
            $display("FAIL power_o t=%0t: got %0d expected %0d", $time, power_o, m_power);
        end
        checks++;
        if (peak_o !== NBITS'(m_peak)) begin
            errors++;
            $display("FAIL peak_o t=%0t: got %0d expected %0d", $time, peak_o, m_peak);
        end
        if (valid_o === 1'b1) begin
            s_pow.push_back(longint'(power_o));
            s_pk.push_back(int'(peak_o));
            s_edge.push_back(ecnt);
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input bit en, input bit clr, input logic [15:0] d0,
                         input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] d3);
        enable_i = en;
        clear_i  = clr;
        dat_i    = {d3, d2, d1, d0};
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 16'd0, 16'd0, 16'd0, 16'd0);
    endtask

    task automatic reset_log();
        s_pow.delete(); s_pk.delete(); s_edge.delete();
    endtask

    initial begin
        int last_edge;
        rst_i = 1'b1; enable_i = 1'b0; clear_i = 1'b0; dat_i = '0;
        repeat (2) @(posedge clk_i);
        #2;
        chk("reset_power", longint'(power_o), 0);
        chk("reset_peak", longint'(peak_o), 0);
        chk("reset_valid", longint'(valid_o), 0);
        rst_i = 1'b0;
        idle(2);

        // 1: single lane constant
        reset_log();
        for (int i = 0; i < WIN; i++) drive(1, 0, 16'd1000, 16'd0, 16'd0, 16'd0);
        last_edge = ecnt;
        idle(5);
        chk("t1_count", s_pow.size(), 1);
        chk("t1_power", s_pow[0], 64'd16000000);
        chk("t1_peak", s_pk[0], 1000);
        chk("t1_latency", s_edge[0] - last_edge, 2);

        // 2: all lanes full-scale negative
        reset_log();
        for (int i = 0; i < WIN; i++) drive(1, 0, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
        idle(5);
        chk("t2_count", s_pow.size(), 1);
        chk("t2_power", s_pow[0], 64'd68719476736);
        chk("t2_peak", s_pk[0], 32768);

        // 3: impulse then an all-zero window
        reset_log();
        drive(1, 0, 16'd0, 16'd0, 16'hFC18, 16'd0);
        for (int i = 0; i < 2*WIN-1; i++) drive(1, 0, 16'd0, 16'd0, 16'd0, 16'd0);
        idle(5);
        chk("t3_count", s_pow.size(), 2);
        chk("t3_power", s_pow[0], 64'd1000000);
        chk("t3_peak", s_pk[0], 1000);
        chk("t3_power2", s_pow[1], 0);
        chk("t3_peak2", s_pk[1], 0);

        // 4: enable toggling, disabled samples are large and must be ignored
        reset_log();
        for (int i = 0; i < WIN; i++) begin
            drive(1, 0, 16'd10, 16'd0, 16'd0, 16'd0);
            last_edge = ecnt;
            drive(0, 0, 16'd5000, 16'd5000, 16'd5000, 16'd5000);
        end
        idle(5);
        chk("t4_count", s_pow.size(), 1);
        chk("t4_power", s_pow[0], 1600);
        chk("t4_peak", s_pk[0], 10);
        chk("t4_latency", s_edge[0] - last_edge, 2);

        // 5: clear after 9 enabled samples, then a clean window
        reset_log();
        for (int i = 0; i < 9; i++) drive(1, 0, 16'd0, 16'd3, 16'd0, 16'd0);
        drive(1, 1, 16'd7777, 16'd7777, 16'd7777, 16'd7777);
        for (int i = 0; i < WIN; i++) drive(1, 0, 16'd0, 16'd3, 16'd0, 16'd0);
        idle(5);
        chk("t5_count", s_pow.size(), 1);
        chk("t5_power", s_pow[0], 144);
        chk("t5_peak", s_pk[0], 3);

        // 6: asynchronous reset mid-window
        reset_log();
        for (int i = 0; i < 5; i++) drive(1, 0, 16'd100, 16'd0, 16'd0, 16'd0);
        enable_i = 1'b0;
        #1 rst_i = 1'b1;
        #1;
        chk("t6_rst_power", longint'(power_o), 0);
        chk("t6_rst_peak", longint'(peak_o), 0);
        #2 rst_i = 1'b0;
        @(posedge clk_i);
        #2;
        for (int i = 0; i < WIN; i++) drive(1, 0, 16'd2, 16'd0, 16'd0, 16'd0);
        last_edge = ecnt;
        idle(5);
        chk("t6_count", s_pow.size(), 1);
        chk("t6_power", s_pow[0], 64);
        chk("t6_peak", s_pk[0], 2);
        chk("t6_latency", s_edge[0] - last_edge, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
